// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    localparam int IMEM_BYTES     = 128;
    localparam int BYTES_PER_WORD = 4;

    // Byte 0 of a word holds bits 31:24; the memory read path relies on the same order.
    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/imem_word_serializer.sv
// rtl/imem_word_serializer.sv - 32-bit load/shift register emitting one byte per cycle
module imem_word_serializer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] word_in,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = word_in;
            idx_d  = 2'd0;
        end else if (shift) begin
            word_d = BYTE_ORDER_MSB_FIRST ? {word_q[23:0], 8'h00} : {8'h00, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign byte_out  = BYTE_ORDER_MSB_FIRST ? word_q[31:24] : word_q[7:0];
    assign last_byte = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams instruction words into the byte-wide imem, holding the core meanwhile
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic              cpu_hold
);

    localparam int SUM_W = ADDR_W + CNT_W + 2;
    localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(2 ** ADDR_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                ser_load, ser_shift;
    logic                ser_last;
    logic [7:0]          ser_byte;
    logic [SUM_W-1:0]    range_end;
    logic                bad_request;

    // Wide enough that the end address can never wrap before the compare.
    assign range_end   = SUM_W'(base_addr) + SUM_W'(word_count) * SUM_W'(BYTES_PER_WORD);
    assign bad_request = (base_addr[1:0] != 2'b00) || (range_end > MEM_LIMIT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        checksum_d = checksum_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    checksum_d = '0;
                    if (bad_request) begin
                        state_d = ERROR;
                    end else if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = base_addr;
                        left_d  = word_count;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    ser_load   = 1'b1;
                    checksum_d = checksum_q + s_data;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                ser_shift = 1'b1;
                addr_d    = addr_q + ADDR_W'(1);
                if (ser_last) begin
                    left_d  = left_q - CNT_W'(1);
                    state_d = (left_q == CNT_W'(1)) ? DONE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            checksum_q <= checksum_d;
        end
    end

    imem_word_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .shift     (ser_shift),
        .word_in   (s_data),
        .byte_out  (ser_byte),
        .last_byte (ser_last)
    );

    assign s_ready   = (state_q == LOAD);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_we ? addr_q : '0;
    assign mem_wdata = mem_we ? ser_byte : '0;
    assign busy      = (state_q == LOAD) || (state_q == WRITE);
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench with an expected-write queue model for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [5:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, mem_we, busy, done, error, cpu_hold;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] checksum;

    imem_loader #(.ADDR_W(7), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .checksum(checksum), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          n_writes = 0;
    int          next_addr = 0;
    int          words_pending = 0;
    bit          in_load = 1'b0;
    logic [31:0] model_sum = '0;
    wr_t         exp_q[$];
    logic [31:0] words_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Model: every accepted word becomes four byte writes, MSB at the lowest address.
    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            wr_t e;
            e.a = 7'(next_addr + i);
            e.d = 8'(w >> (8 * (BYTES_PER_WORD - 1 - i)));
            exp_q.push_back(e);
        end
        next_addr += BYTES_PER_WORD;
        model_sum += w;
        words_pending--;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("cpu_hold_eq_busy", {31'b0, cpu_hold}, {31'b0, busy});
            if (in_load) check("cpu_hold_in_load", {31'b0, cpu_hold}, 32'd1);
            if (mem_we) begin
                n_writes++;
                check("ready_during_write", {31'b0, s_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_we", {31'b0, mem_we}, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", {25'b0, mem_addr}, {25'b0, e.a});
                    check("mem_wdata", {24'b0, mem_wdata}, {24'b0, e.d});
                    if (exp_q.size() == 0 && words_pending == 0) in_load = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start(input int b, input int c);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 7'(b);
        word_count = 6'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        bit accepted = 1'b0;
        @(posedge clk); #1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data = w;
        push_word(w);
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            if (s_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!accepted) check("accept_timeout", {31'b0, s_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("busy_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_load(input int b, input int c, input int gap, input bit inject);
        bit exp_err;
        bit exp_busy;
        exp_err = (b % BYTES_PER_WORD != 0) || (b + BYTES_PER_WORD * c > IMEM_BYTES);
        exp_busy = !exp_err && (c != 0);
        model_sum = '0;
        next_addr = b;
        words_pending = exp_busy ? c : 0;
        pulse_start(b, c);
        in_load = exp_busy;
        @(negedge clk);
        check("error_after_start", {31'b0, error}, {31'b0, exp_err});
        check("done_after_start", {31'b0, done}, {31'b0, !exp_err && c == 0});
        check("busy_after_start", {31'b0, busy}, {31'b0, exp_busy});
        check("checksum_cleared", checksum, 32'd0);
        if (exp_busy) begin
            for (int i = 0; i < c; i++) begin
                send_word(words_q[i], gap);
                if (inject && i == 0) begin
                    start = 1'b1;
                    base_addr = 7'd64;
                    word_count = 6'd1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            wait_idle();
            check("done_final", {31'b0, done}, 32'd1);
            check("error_final", {31'b0, error}, 32'd0);
            check("checksum_final", checksum, model_sum);
            check("writes_outstanding", exp_q.size(), 32'd0);
        end else begin
            repeat (3) @(negedge clk);
            check("idle_no_ready", {31'b0, s_ready}, 32'd0);
        end
    endtask

    initial begin
        int target;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {22'b0, s_ready, mem_we, busy, done, error, cpu_hold, 4'b0},
              32'd0);
        check("rst_checksum", checksum, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        words_q = '{32'h0800_0002};
        run_load(0, 1, 0, 1'b0);
        check("single_checksum_lit", checksum, 32'h0800_0002);
        check("single_write_count", n_writes, 32'd4);
        check("single_busy", {31'b0, busy}, 32'd0);

        words_q = '{32'h0001_1020, 32'h0001_1824, 32'h0001_3025};
        run_load(8, 3, 3, 1'b0);
        check("three_checksum_lit", checksum, 32'h0003_5869);
        check("three_write_count", n_writes, 32'd16);

        run_load(124, 2, 0, 1'b0);
        check("range_error_lit", {31'b0, error}, 32'd1);
        run_load(2, 1, 0, 1'b0);
        check("align_error_lit", {31'b0, error}, 32'd1);
        check("error_no_writes", n_writes, 32'd16);

        words_q = '{32'hDEAD_BEEF};
        run_load(124, 1, 0, 1'b0);

        s_valid = 1'b1;
        s_data = 32'h5555_AAAA;
        run_load(0, 0, 0, 1'b0);
        check("zero_done_lit", {31'b0, done}, 32'd1);
        s_valid = 1'b0;

        words_q = '{32'h0102_0304, 32'hA0B0_C0D0};
        run_load(16, 2, 0, 1'b1);

        model_sum = '0;
        next_addr = 0;
        words_pending = 2;
        pulse_start(0, 2);
        in_load = 1'b1;
        target = n_writes + 2;
        send_word(32'h1122_3344, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (n_writes >= target) break;
        end
        check("pre_reset_writes", n_writes, target);
        reset = 1'b0;
        exp_q.delete();
        in_load = 1'b0;
        words_pending = 0;
        @(negedge clk);
        check("midrst_flags", {26'b0, s_ready, mem_we, busy, done, error, cpu_hold}, 32'd0);
        check("midrst_bus", {17'b0, mem_addr, mem_wdata}, 32'd0);
        check("midrst_checksum", checksum, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        words_q = '{32'hAC02_000C};
        run_load(40, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=0", 1);
        $fatal(1, "timeout");
    end

endmodule
